// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle-based CDC pulse channel cells.
package cdc_pkg;

   // Destination-side FSM: ARM absorbs the reset-time toggle level, RUN forwards events.
   typedef enum logic {
      ARM = 1'b0,
      RUN = 1'b1
   } rx_state_t;

   // Fewest synchronizer flops allowed on an asynchronous input.
   localparam int unsigned SYNC_STAGES_MIN = 2;

endpackage : cdc_pkg

// File: rtl/cdc_sync_bit.sv
// N-flop single-bit synchronizer with asynchronous active-low reset to 0.
// The attributes keep the chain intact and let the tools place it tightly.
module cdc_sync_bit #(
   parameter int unsigned N = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) (* keep = "true" *) logic [N-1:0] sync_q;

   // Shift the asynchronous input through the flop chain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= d;
         for (int i = 1; i < int'(N); i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign q = sync_q[N-1];

endmodule : cdc_sync_bit

// File: rtl/tgl2pls_rx.sv
// Destination cell of the toggle CDC pulse channel: resynchronises tgl_in, turns each
// toggle edge into a one-cycle pulse, buffers events in a saturating counter behind
// valid/ready, and returns an acknowledge toggle per accepted event.
module tgl2pls_rx
   import cdc_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_W       = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tgl_in,
   output logic             pulse,
   output logic             ev_valid,
   input  logic             ev_ready,
   output logic [CNT_W-1:0] pending,
   output logic             ovf,
   input  logic             ovf_clr,
   output logic             ack_tgl,
   output logic             armed
);

   // Wide enough to hold the terminal arm count SYNC_STAGES.
   localparam int unsigned ARM_W = $clog2(SYNC_STAGES + 2);

   if (SYNC_STAGES < SYNC_STAGES_MIN) begin : g_bad_sync
      $error("tgl2pls_rx: SYNC_STAGES must be at least %0d", SYNC_STAGES_MIN);
   end

   rx_state_t        state_q, state_d;
   logic [ARM_W-1:0] arm_cnt_q, arm_cnt_d;
   logic [CNT_W-1:0] pending_q, pending_d;
   logic             ovf_q, ovf_d;
   logic             ack_q, ack_d;
   logic             s_last;
   logic             tgl_d;
   logic             tgl_edge;
   logic             accept;
   logic             full;

   cdc_sync_bit #(
      .N (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (tgl_in),
      .q     (s_last)
   );

   // Previous synchronised level; tracks s_last in both states so ARM absorbs it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tgl_d <= 1'b0;
      end else begin
         tgl_d <= s_last;
      end
   end

   assign tgl_edge = s_last ^ tgl_d;
   assign pulse    = tgl_edge & (state_q == RUN);
   assign ev_valid = (pending_q != '0);
   assign accept   = ev_valid & ev_ready;
   assign full     = (pending_q == '1);

   // State, arm counter, pending count, overflow flag and ack toggle registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ARM;
         arm_cnt_q <= '0;
         pending_q <= '0;
         ovf_q     <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         arm_cnt_q <= arm_cnt_d;
         pending_q <= pending_d;
         ovf_q     <= ovf_d;
         ack_q     <= ack_d;
      end
   end

   // Arming sequence: SYNC_STAGES+1 edges in ARM, then RUN until reset.
   always_comb begin
      state_d   = state_q;
      arm_cnt_d = arm_cnt_q;
      unique case (state_q)
         ARM: begin
            arm_cnt_d = arm_cnt_q + ARM_W'(1);
            if (arm_cnt_q == ARM_W'(SYNC_STAGES)) begin
               state_d = RUN;
            end
         end
         RUN: begin
            state_d = RUN;
         end
         default: begin
            state_d = ARM;
         end
      endcase
   end

   // Pending counter: pulse adds, accept removes, both together cancel out.
   always_comb begin
      pending_d = pending_q;
      ovf_d     = ovf_q;
      ack_d     = ack_q ^ accept;
      if (pulse && !accept) begin
         if (full) begin
            ovf_d = 1'b1;
         end else begin
            pending_d = pending_q + CNT_W'(1);
         end
      end else if (accept && !pulse) begin
         pending_d = pending_q - CNT_W'(1);
      end
      // A fresh overflow beats a simultaneous clear.
      if (ovf_clr && !(pulse && !accept && full)) begin
         ovf_d = 1'b0;
      end
   end

   assign pending = pending_q;
   assign ovf     = ovf_q;
   assign ack_tgl = ack_q;
   assign armed   = (state_q == RUN);

endmodule : tgl2pls_rx
